sram_access_arbiter: RTL
========================

// Module: sram_access_arbiter
// PURPOSE
//  Shares the single external SRAM port between three requesters: display reader (DSP, read-only,
//  strict highest priority, never stalled), decoder (DEC, read/write) and loader (LDR, write-only).
//  One SRAM access per clock. DEC and LDR are served round-robin in cycles DSP leaves idle.
//  Drives the SRAM address/data/write-enable pins and returns read data to the owner, tagged.
// PARAMETERS
//  ADDR_W        18   SRAM word-address width
//  DATA_W        16   SRAM data width
//  RD_LAT        2    cycles from grant cycle to read-data cycle (fixed by SRAM timing)
//  STARVE_LIMIT  1023 wait cycles after which a DEC/LDR request raises starve_err
// PORTS
//  Clock            in   1       system clock, rising edge
//  Reset            in   1       asynchronous, active-high reset
//  dsp_req          in   1       DSP read request (no ack; always granted)
//  dsp_addr         in   ADDR_W  DSP read address
//  dec_req          in   1       DEC request; held with dec_we/addr/wdata until dec_gnt
//  dec_we           in   1       1 = write, 0 = read
//  dec_addr         in   ADDR_W  DEC address
//  dec_wdata        in   DATA_W  DEC write data
//  dec_gnt          out  1       combinational grant, same cycle as accepted request
//  ldr_req          in   1       LDR write request; held until ldr_gnt
//  ldr_addr         in   ADDR_W  LDR address
//  ldr_wdata        in   DATA_W  LDR write data
//  ldr_gnt          out  1       combinational grant
//  rd_data          out  DATA_W  SRAM_read_data passthrough
//  dsp_rvalid       out  1       rd_data belongs to a DSP read this cycle
//  dec_rvalid       out  1       rd_data belongs to a DEC read this cycle
//  starve_err       out  1       sticky: DEC or LDR waited STARVE_LIMIT cycles
//  SRAM_address     out  ADDR_W  registered SRAM address
//  SRAM_write_data  out  DATA_W  registered SRAM write data
//  SRAM_write_en_n  out  1       registered, active-low write enable
//  SRAM_read_data   in   DATA_W  SRAM read data
// BEHAVIOUR
//  Reset values: SRAM_address 0, SRAM_write_data 0, SRAM_write_en_n 1, rvalids 0, starve_err 0,
//   RR pointer = DEC, wait counters 0, read-tag pipeline cleared.
//  Arbitration (cycle G, combinational): dsp_req wins outright; else if exactly one of dec_req/ldr_req
//   is high it wins; if both, the RR-pointer port wins. Pointer moves to the other port after each
//   DEC/LDR grant; unchanged on DSP-only or idle cycles. At most one grant per cycle.
//  Issue (edge ending G): SRAM_address <= winner addr; write: SRAM_write_data <= wdata,
//   SRAM_write_en_n <= 0 for exactly cycle G+1; read or idle: SRAM_write_en_n <= 1.
//   Idle cycle: SRAM_address and SRAM_write_data hold.
//  Read return: tag {valid, port} shifts through RD_LAT-1 registers plus issue stage; the matching
//   rvalid is high in cycle G+RD_LAT exactly, when the owner captures rd_data. Back-to-back reads
//   from mixed owners return in issue order, one per cycle. Write-after-read and read-after-write
//   need no bubble.
//  Starvation: per-port 10-bit saturating wait counter increments each cycle req high and no grant,
//   clears on grant or req low; reaching STARVE_LIMIT sets starve_err until Reset. Grants unaffected.
//  Boundaries: address wrap is the requester's responsibility (no arithmetic here); requester
//   dropping req before gnt = withdrawn, no access; simultaneous DSP+DEC+LDR -> DSP, pointer unchanged;
//   Reset mid-operation -> in-flight reads discarded, no rvalid after Reset deasserts, write enable
//   returns high immediately (asynchronously).
// STRUCTURE
//  Package sram_arb_pkg: typedef enum {PORT_NONE, PORT_DSP, PORT_DEC, PORT_LDR} sram_port_t;
//   localparam RD_LAT default; read-tag struct {logic valid; sram_port_t port;}.
//  Sub-module sram_arb_rr: 2-way round-robin pick with pointer register (DEC/LDR).
//  Top: priority mux, issue registers, tag shift pipeline, wait counters, starve_err.
// TESTING
//  1 Reset then idle 10 cycles -> SRAM_write_en_n=1, SRAM_address=0, no rvalid, starve_err=0.
//  2 DSP reads 0x100..0x103 back-to-back -> addresses on pins cycles 1..4, dsp_rvalid cycles 2..5.
//  3 DEC+LDR both requesting, DSP idle, 4 cycles -> grants DEC,LDR,DEC,LDR; write_en_n low each write.
//  4 DSP continuous, DEC read pending 1023 cycles -> dec_gnt never, starve_err=1 at 1023rd wait cycle.
//  5 DEC read 0x2A, DSP read 0x3B next cycle -> dec_rvalid G+2, dsp_rvalid G+3, data matches model.
//  6 Reset asserted one cycle after a DSP read grant -> no dsp_rvalid afterwards, pins return to reset values.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and defaults for the SRAM access arbiter
package sram_arb_pkg;

  localparam int RD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_DSP  = 2'd1,
    PORT_DEC  = 2'd2,
    PORT_LDR  = 2'd3
  } sram_port_t;

  typedef struct packed {
    logic       valid;
    sram_port_t port;
  } rd_tag_t;

endpackage

// File: rtl/sram_arb_rr.sv
// rtl/sram_arb_rr.sv - two-way round-robin pick between decoder and loader
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_dec_req,
  input  logic i_ldr_req,
  output logic o_dec_gnt,
  output logic o_ldr_gnt
);

  sram_port_t r_ptr;

  // Grant the lone requester, or the pointed-to port when both want the slot
  always_comb begin
    o_dec_gnt = 1'b0;
    o_ldr_gnt = 1'b0;
    if (i_en) begin
      if (i_dec_req && (!i_ldr_req || r_ptr == PORT_DEC)) begin
        o_dec_gnt = 1'b1;
      end else if (i_ldr_req) begin
        o_ldr_gnt = 1'b1;
      end
    end
  end

  // Pointer hands priority to the other port after each grant it issues
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= PORT_DEC;
    end else if (o_dec_gnt) begin
      r_ptr <= PORT_LDR;
    end else if (o_ldr_gnt) begin
      r_ptr <= PORT_DEC;
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - single-port SRAM arbiter for display, decoder and loader
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int RD_LAT       = RD_LAT_DEF,
  parameter int STARVE_LIMIT = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_dsp_req,
  input  logic [ADDR_W-1:0] i_dsp_addr,
  input  logic              i_dec_req,
  input  logic              i_dec_we,
  input  logic [ADDR_W-1:0] i_dec_addr,
  input  logic [DATA_W-1:0] i_dec_wdata,
  output logic              o_dec_gnt,
  input  logic              i_ldr_req,
  input  logic [ADDR_W-1:0] i_ldr_addr,
  input  logic [DATA_W-1:0] i_ldr_wdata,
  output logic              o_ldr_gnt,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_dsp_rvalid,
  output logic              o_dec_rvalid,
  output logic              o_starve_err,
  output logic [ADDR_W-1:0] o_sram_address,
  output logic [DATA_W-1:0] o_sram_write_data,
  output logic              o_sram_write_en_n,
  input  logic [DATA_W-1:0] i_sram_read_data
);

  localparam logic [9:0] LIMIT = 10'(STARVE_LIMIT);

  logic              w_dec_gnt;
  logic              w_ldr_gnt;
  sram_port_t        w_port;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_we;
  rd_tag_t           w_tag_in;
  logic              w_dec_wait;
  logic              w_ldr_wait;
  logic [9:0]        w_dec_cnt_nxt;
  logic [9:0]        w_ldr_cnt_nxt;

  logic [ADDR_W-1:0] r_sram_address;
  logic [DATA_W-1:0] r_sram_write_data;
  logic              r_sram_write_en_n;
  rd_tag_t           r_tag [RD_LAT];
  logic [9:0]        r_dec_cnt;
  logic [9:0]        r_ldr_cnt;
  logic              r_starve_err;

  // DSP owns the slot whenever it asks, so round-robin only runs when DSP is idle
  sram_arb_rr u_rr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (~i_dsp_req),
    .i_dec_req (i_dec_req),
    .i_ldr_req (i_ldr_req),
    .o_dec_gnt (w_dec_gnt),
    .o_ldr_gnt (w_ldr_gnt)
  );

  // Priority mux: select this cycle's owner and what goes to the pins
  always_comb begin
    w_port  = PORT_NONE;
    w_addr  = r_sram_address;
    w_wdata = r_sram_write_data;
    w_we    = 1'b0;
    if (i_dsp_req) begin
      w_port = PORT_DSP;
      w_addr = i_dsp_addr;
    end else if (w_dec_gnt) begin
      w_port  = PORT_DEC;
      w_addr  = i_dec_addr;
      w_wdata = i_dec_wdata;
      w_we    = i_dec_we;
    end else if (w_ldr_gnt) begin
      w_port  = PORT_LDR;
      w_addr  = i_ldr_addr;
      w_wdata = i_ldr_wdata;
      w_we    = 1'b1;
    end
    w_tag_in.valid = (w_port != PORT_NONE) && !w_we;
    w_tag_in.port  = w_port;
  end

  // Issue stage: register pins; write enable low only for the cycle after a write grant
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sram_address    <= '0;
      r_sram_write_data <= '0;
      r_sram_write_en_n <= 1'b1;
    end else begin
      r_sram_address    <= w_addr;
      r_sram_write_en_n <= ~w_we;
      if (w_we) begin
        r_sram_write_data <= w_wdata;
      end
    end
  end

  // Read tags follow the access so returning data is attributed to its owner
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Wait counters saturate so a very long stall cannot wrap back below the limit
  always_comb begin
    w_dec_wait    = i_dec_req && !w_dec_gnt;
    w_ldr_wait    = i_ldr_req && !w_ldr_gnt;
    w_dec_cnt_nxt = '0;
    w_ldr_cnt_nxt = '0;
    if (w_dec_wait) begin
      w_dec_cnt_nxt = (r_dec_cnt == '1) ? r_dec_cnt : r_dec_cnt + 10'd1;
    end
    if (w_ldr_wait) begin
      w_ldr_cnt_nxt = (r_ldr_cnt == '1) ? r_ldr_cnt : r_ldr_cnt + 10'd1;
    end
  end

  // Starvation flag stays set until reset once either port hits the limit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dec_cnt    <= '0;
      r_ldr_cnt    <= '0;
      r_starve_err <= 1'b0;
    end else begin
      r_dec_cnt <= w_dec_cnt_nxt;
      r_ldr_cnt <= w_ldr_cnt_nxt;
      if ((w_dec_wait && w_dec_cnt_nxt >= LIMIT) || (w_ldr_wait && w_ldr_cnt_nxt >= LIMIT)) begin
        r_starve_err <= 1'b1;
      end
    end
  end

  assign o_dec_gnt         = w_dec_gnt & ~i_dsp_req;
  assign o_ldr_gnt         = w_ldr_gnt & ~i_dsp_req;
  assign o_rd_data         = i_sram_read_data;
  assign o_dsp_rvalid      = r_tag[RD_LAT-1].valid && (r_tag[RD_LAT-1].port == PORT_DSP);
  assign o_dec_rvalid      = r_tag[RD_LAT-1].valid && (r_tag[RD_LAT-1].port == PORT_DEC);
  assign o_starve_err      = r_starve_err;
  assign o_sram_address    = r_sram_address;
  assign o_sram_write_data = r_sram_write_data;
  assign o_sram_write_en_n = r_sram_write_en_n;

endmodule
